seq_barrel_shifter: RTL



---
 rtl/seq_barrel_shifter_pkg.sv | 14 +
 rtl/seq_barrel_shifter_if.sv | 21 ++
 rtl/seq_barrel_shifter_stage.sv | 20 ++
 rtl/seq_barrel_shifter.sv | 99 +++++++++
 4 files changed

// File: rtl/seq_barrel_shifter_pkg.sv
// seq_shifter_pkg: shift-mode and FSM-state encodings shared by the sequential barrel shifter.
package seq_shifter_pkg;
    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;
endpackage

// File: rtl/seq_barrel_shifter_if.sv
// seq_barrel_shifter_if: request/response handshake bundle between the pipeline and the shifter.
interface seq_barrel_shifter_if #(parameter int WIDTH = 32);
    localparam int SHW = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    modport master (
        output in_valid, data_in, shamt, mode, out_ready,
        input  in_ready, out_valid, data_out, busy
    );
    modport slave (
        input  in_valid, data_in, shamt, mode, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/seq_barrel_shifter_stage.sv
// shifter_stage: one log2 barrel stage shifting by DIST when enabled; right shifts take their fill from mode.
module shifter_stage
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] i_word,
    input  mode_t            i_mode,
    input  logic             i_sign,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_word
);
    logic [DIST-1:0] w_fill;
    assign w_fill = i_mode == MODE_SRA ? {DIST{i_sign}} :
                    i_mode == MODE_ROR ? i_word[DIST-1:0] : '0;
    assign o_word = !i_enable          ? i_word :
                    i_mode == MODE_SLL ? {i_word[WIDTH-DIST-1:0], {DIST{1'b0}}} :
                                         {w_fill, i_word[WIDTH-1:DIST]};
endmodule

// File: rtl/seq_barrel_shifter.sv
// seq_barrel_shifter: multi-cycle shifter applying one barrel stage per clock behind valid/ready handshakes.
// Optional SEQ_SHIFTER_EARLY_DONE_EN finishes as soon as no higher shamt bits remain.
module seq_barrel_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    seq_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    state_t           r_state;
    logic [WIDTH-1:0] r_word;
    logic [SHW-1:0]   r_shamt;
    logic [SHW-1:0]   r_k;
    mode_t            r_mode;
    logic             r_sign;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] w_stage [SHW];
    logic [WIDTH-1:0] w_next;
    logic             w_last;

    for (genvar i = 0; i < SHW; i++) begin : g_stage
        shifter_stage #(.WIDTH(WIDTH), .DIST(1 << i)) u_stage (
            .i_word   (r_word),
            .i_mode   (r_mode),
            .i_sign   (r_sign),
            .i_enable (r_shamt[i]),
            .o_word   (w_stage[i])
        );
    end

    always_comb begin
        w_next = r_word;
        for (int j = 0; j < SHW; j++) w_next = r_k == SHW'(j) ? w_stage[j] : w_next;
    end

`ifdef SEQ_SHIFTER_EARLY_DONE_EN
    // Last stage once no set shamt bit remains above k.
    assign w_last = (r_shamt >> r_k) <= SHW'(1);
`else
    assign w_last = r_k == SHW'(SHW - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_shamt     <= '0;
            r_k         <= '0;
            r_mode      <= MODE_SLL;
            r_sign      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.in_valid) begin
                    r_word     <= bus.data_in;
                    r_shamt    <= bus.shamt;
                    r_mode     <= mode_t'(bus.mode);
                    r_sign     <= bus.data_in[WIDTH-1];
                    r_k        <= '0;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
`ifdef SEQ_SHIFTER_EARLY_DONE_EN
                    r_state     <= bus.shamt == '0 ? ST_DONE : ST_RUN;
                    r_out_valid <= bus.shamt == '0;
`else
                    r_state     <= ST_RUN;
`endif
                end
                ST_RUN: begin
                    r_word <= w_next;
                    r_k    <= r_k + 1'b1;
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: if (bus.out_ready) begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_word;
    assign bus.busy      = r_busy;
endmodule
